nubus_master_burst: RTL
=======================

Name: nubus_master_burst

Overview:
Next-generation NuBus master engine with parametrised block-transfer length, automatic try-again-later retry with backoff, a watchdog and a decoded status return. Sits between the CPU-side request port and the NuBus pad/arbiter logic. All bus signals here are decoded active-high; inversion, tri-stating and arbitration-contest logic stay in the pad and arbiter blocks.

Parameters:
BURST_MAX, 16, largest block in words; legal values 2, 4, 8, 16.
WDT_W, 8, watchdog width; timeout after 2^WDT_W cycles without an acknowledge.
RETRY_MAX, 3, retries after try-again-later before the error is reported.
BACKOFF_W, 4, backoff counter width; wait 2^BACKOFF_W cycles before re-arbitrating.

Ports:
nub_clk  in  1  bus clock; all logic on rising edge
nub_reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  request accepted (IDLE only)
req_addr  in  32  word address; bits 1:0 ignored
req_write  in  1  1 = write, 0 = read
req_len  in  5  words: 1 = single, else 2/4/8/16 block
req_lock  in  1  keep bus ownership after this transaction
wr_data  in  32  write beat data
wr_ready  out  1  write beat consumed this cycle
rd_data  out  32  read beat data
rd_valid  out  1  read beat strobe, one cycle per beat
done  out  1  one-cycle completion pulse
status  out  2  00 ok, 01 slave error, 10 watchdog timeout, 11 retry exhausted; valid with done
arb_grant  in  1  arbiter won
bus_busy  in  1  another transaction in progress
rqst  out  1  drive bus request
start  out  1  drive start (address cycle)
ad_o  out  32  address/data to pads
ad_oe  out  1  pad output enable for AD
tm_o  out  2  transfer mode during address cycle
ack  in  1  final acknowledge
blk_ack  in  1  intermediate block-beat acknowledge
tm_i  in  2  slave status with ack: 00 ok, 01 error, 10 bus timeout, 11 try-again-later
ad_i  in  32  bus data for reads

Behaviour:
- Reset: state IDLE; req_ready=1; rqst, start, ad_oe, wr_ready, rd_valid, done = 0; status=00; ad_o, tm_o, rd_data = 0; all counters 0.
- IDLE: on req_valid & req_ready, latch addr, write, len and lock; go to ARB. An illegal req_len (0, 3, or > BURST_MAX) is accepted, produces done with status 01 the next cycle, and never touches the bus.
- ARB: rqst=1. When arb_grant & ~bus_busy, go to ADDR.
- ADDR (exactly 1 cycle): start=1, ad_oe=1.
  - Single: ad_o = address; tm_o = {~write, 0}.
  - Block: ad_o = address with bits 5:2 encoding block size (2->0001, 4->0010, 8->0100, 16->1000); tm_o = {~write, 1}.
  - Write: first wr_data beat presented the following cycle.
  - rqst drops in ADDR unless the lock flag is set.
- DATA: beat counter counts from 0 to len-1.
  - Write: ad_oe=1, ad_o=wr_data; wr_ready pulses on each blk_ack and on the final ack.
  - Read: ad_oe=0; on each blk_ack or ack, rd_data=ad_i and rd_valid=1 in the next cycle.
  - A blk_ack on the last beat is ignored.
  - An ack before the last beat terminates the transfer early.
  - If ack & blk_ack arrive together, ack wins.
- Final ack, by tm_i:
  - 00: done, status 00.
  - 01 or 10: done, status 01 or 10.
  - 11: if retry count < RETRY_MAX, increment it and go to BACKOFF; else done, status 11.
  - On any termination the beat counter restarts on retry, and the address and len are restored.
- BACKOFF: count 2^BACKOFF_W cycles with rqst=0, then go to ARB.
- Watchdog:
  - Counter clears on entry to ADDR and on every blk_ack.
  - Saturation at 2^WDT_W-1 in DATA forces done, status 10, ad_oe=0, and return to IDLE.
- DONE (1 cycle): done=1, then IDLE.
  - If lock is set, rqst stays 1 through IDLE.
  - While rqst is held, the next accepted request skips ARB and goes directly to ADDR when ~bus_busy.
  - A request arriving with req_lock=0 releases rqst after its ADDR cycle.
- req_ready is 1 only in IDLE; inputs are ignored elsewhere. Reset mid-transaction returns to IDLE immediately, with no done pulse and rqst=0.

Test Plan:
- Single write, addr 0xF3000010, data 0xDEADBEEF, ack tm_i=00 after 3 cycles -> start 1 cycle with ad_o=0xF3000010, tm_o=00; ad_o=0xDEADBEEF in DATA; one wr_ready; done with status 00.
- Block read, len 4, addr 0xF3000100, blk_ack x3 then ack, ad_i=1,2,3,4 -> ad_o address bits 5:2=0010, tm_o=11; four rd_valid pulses carrying 1,2,3,4; done, status 00.
- Try-again-later returned 4 times, RETRY_MAX=3 -> three BACKOFF periods of 16 cycles each with rqst=0; four ADDR cycles; done, status 11.
- No ack, WDT_W=4 -> done, status 10, exactly 16 cycles after start; ad_oe=0.
- Locked pair: req_lock=1 write, then req_lock=0 read -> rqst continuous from the first ARB through the second ADDR; no arbitration wait for the second request.
- req_len=3 -> rqst never asserted; done, status 01 one cycle after accept.
- Reset asserted during DATA of a 16-beat write -> next cycle IDLE, rqst=0, ad_oe=0, no done pulse.

Source files
------------

// File: rtl/nubus_master_burst_if.sv
// CPU request port and decoded NuBus pad/arbiter signals for the burst master.
// The master modport is the engine; the slave modport is the CPU plus pads/arbiter.
interface nubus_master_burst_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [4:0]  req_len;
    logic        req_lock;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic [1:0]  status;
    logic        arb_grant;
    logic        bus_busy;
    logic        rqst;
    logic        start;
    logic [31:0] ad_o;
    logic        ad_oe;
    logic [1:0]  tm_o;
    logic        ack;
    logic        blk_ack;
    logic [1:0]  tm_i;
    logic [31:0] ad_i;

    modport master (
        input  req_valid, req_addr, req_write, req_len, req_lock, wr_data,
               arb_grant, bus_busy, ack, blk_ack, tm_i, ad_i,
        output req_ready, wr_ready, rd_data, rd_valid, done, status,
               rqst, start, ad_o, ad_oe, tm_o
    );

    modport slave (
        output req_valid, req_addr, req_write, req_len, req_lock, wr_data,
               arb_grant, bus_busy, ack, blk_ack, tm_i, ad_i,
        input  req_ready, wr_ready, rd_data, rd_valid, done, status,
               rqst, start, ad_o, ad_oe, tm_o
    );
endinterface

// File: rtl/nubus_master_burst.sv
// NuBus master engine: single/block transfers, try-again-later retry with backoff,
// watchdog on missing acknowledge, and bus-ownership hold for locked sequences.
module nubus_master_burst #(
    parameter int BURST_MAX = 16,
    parameter int WDT_W     = 8,
    parameter int RETRY_MAX = 3,
    parameter int BACKOFF_W = 4
) (
    input  logic                 nub_clk,
    input  logic                 nub_reset,
    nubus_master_burst_if.master bus
);
    localparam int RTY_W = $clog2(RETRY_MAX + 2);
    localparam logic [RTY_W-1:0]     RETRY_LIM = RTY_W'(RETRY_MAX);
    localparam logic [WDT_W-1:0]     WDT_SAT   = '1;
    localparam logic [BACKOFF_W-1:0] BO_END    = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ADDR, S_DATA, S_BACKOFF, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SLV_ERR = 2'b01,
        ST_WDT     = 2'b10,
        ST_RETRY   = 2'b11
    } status_e;

    state_e               state_q, state_d;
    status_e              status_q, status_d;
    logic [31:0]          addr_q, addr_d;
    logic                 write_q, write_d;
    logic [4:0]           len_q, len_d;
    logic                 lock_q, lock_d;
    logic                 own_q, own_d;
    logic [4:0]           beat_q, beat_d;
    logic [WDT_W-1:0]     wdt_q, wdt_d;
    logic [BACKOFF_W-1:0] bo_q, bo_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic len_ok;
    logic is_block;
    logic last_beat;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            addr_q     <= '0;
            write_q    <= 1'b0;
            len_q      <= '0;
            lock_q     <= 1'b0;
            own_q      <= 1'b0;
            beat_q     <= '0;
            wdt_q      <= '0;
            bo_q       <= '0;
            retry_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            len_q      <= len_d;
            lock_q     <= lock_d;
            own_q      <= own_d;
            beat_q     <= beat_d;
            wdt_q      <= wdt_d;
            bo_q       <= bo_d;
            retry_q    <= retry_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        len_ok = 1'b0;
        case (bus.req_len)
            5'd1:                    len_ok = 1'b1;
            5'd2, 5'd4, 5'd8, 5'd16: len_ok = (int'({27'd0, bus.req_len}) <= BURST_MAX);
            default:                 len_ok = 1'b0;
        endcase
    end

    assign is_block  = (len_q != 5'd1);
    assign last_beat = (beat_q == len_q - 5'd1);

    assign bus.status   = status_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        addr_d     = addr_q;
        write_d    = write_q;
        len_d      = len_q;
        lock_d     = lock_q;
        own_d      = own_q;
        beat_d     = beat_q;
        wdt_d      = wdt_q;
        bo_d       = bo_q;
        retry_d    = retry_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        bus.req_ready = 1'b0;
        bus.rqst      = own_q;
        bus.start     = 1'b0;
        bus.ad_o      = '0;
        bus.ad_oe     = 1'b0;
        bus.tm_o      = '0;
        bus.wr_ready  = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    len_d   = bus.req_len;
                    lock_d  = bus.req_lock;
                    retry_d = '0;
                    beat_d  = '0;
                    wdt_d   = '0;
                    if (!len_ok) begin
                        status_d = ST_SLV_ERR;
                        state_d  = S_DONE;
                    end else if (own_q && !bus.bus_busy) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_ARB;
                    end
                end
            end

            S_ARB: begin
                bus.rqst = 1'b1;
                // A held bus (locked sequence) only has to wait for the current owner to finish.
                if ((bus.arb_grant || own_q) && !bus.bus_busy) begin
                    beat_d  = '0;
                    wdt_d   = '0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                bus.rqst  = 1'b1;
                bus.start = 1'b1;
                bus.ad_oe = 1'b1;
                bus.ad_o  = is_block ? {addr_q[31:6], len_q[4:1], 2'b00}
                                     : (addr_q & 32'hFFFF_FFFC);
                bus.tm_o  = {~write_q, is_block};
                own_d     = lock_q;
                wdt_d     = wdt_q + WDT_W'(1);
                state_d   = S_DATA;
            end

            S_DATA: begin
                bus.ad_oe = write_q;
                bus.ad_o  = write_q ? bus.wr_data : 32'd0;
                if (bus.ack) begin
                    bus.wr_ready = write_q;
                    rd_valid_d   = ~write_q;
                    if (!write_q) rd_data_d = bus.ad_i;
                    state_d = S_DONE;
                    case (bus.tm_i)
                        2'b00: status_d = ST_OK;
                        2'b01: status_d = ST_SLV_ERR;
                        2'b10: status_d = ST_WDT;
                        default: begin
                            if (retry_q < RETRY_LIM) begin
                                retry_d = retry_q + RTY_W'(1);
                                bo_d    = '0;
                                own_d   = 1'b0;
                                state_d = S_BACKOFF;
                            end else begin
                                status_d = ST_RETRY;
                            end
                        end
                    endcase
                end else if (bus.blk_ack && !last_beat) begin
                    bus.wr_ready = write_q;
                    rd_valid_d   = ~write_q;
                    if (!write_q) rd_data_d = bus.ad_i;
                    beat_d = beat_q + 5'd1;
                    wdt_d  = '0;
                end else if (wdt_q == WDT_SAT) begin
                    bus.ad_oe = 1'b0;
                    status_d  = ST_WDT;
                    state_d   = S_DONE;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end

            S_BACKOFF: begin
                bus.rqst = 1'b0;
                bo_d     = bo_q + BACKOFF_W'(1);
                if (bo_q == BO_END) state_d = S_ARB;
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end
endmodule
